// File: rtl/sim_run_sequencer.sv
// Run controller for the processor test harness: loads the program, resets and runs the DUT,
// dumps a data-memory window to the output sink, then raises end_sim.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for start; DUT held in reset
//  LOAD  | streaming program words into the instruction memory
//  HOLD  | DUT held in reset for RST_CYC cycles
//  RUN   | DUT running and owns the data-memory port
//  DUMP  | DUT frozen; sequencer reads the dump window into the sink
//  DONE  | end_sim raised; only reset leaves
module sim_run_sequencer #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_WORDS = 256,
    parameter int                RST_CYC    = 4,
    parameter int                RUN_CYC    = 1000,
    parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
    parameter int                DUMP_WORDS = 64
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    output logic              ld_en,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_eof,
    output logic              imem_cs,
    output logic              imem_wr_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_din,
    output logic              dut_rst_n,
    input  logic              dut_halt,
    input  logic              dut_dm_rd,
    input  logic              dut_dm_wr,
    input  logic [ADDR_W-1:0] dut_dm_addr,
    input  logic [DATA_W-1:0] dut_dm_din,
    output logic              dm_cs,
    output logic              dm_rd,
    output logic              dm_wr_n,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout,
    output logic              sink_en,
    output logic [DATA_W-1:0] sink_data,
    output logic              end_sim,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DUMP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] wcnt_q, wcnt_d;
    // Shared phase counter: hold cycles, run cycles, or dump slot index.
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        cnt_d     = cnt_q;
        ld_en     = 1'b0;
        imem_cs   = 1'b0;
        imem_wr_n = 1'b1;
        imem_addr = '0;
        imem_din  = '0;
        dut_rst_n = 1'b0;
        dm_cs     = 1'b0;
        dm_rd     = 1'b0;
        dm_wr_n   = 1'b1;
        dm_addr   = '0;
        dm_din    = '0;
        sink_en   = 1'b0;
        sink_data = '0;
        end_sim   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                ld_en = 1'b1;
                if (ld_valid && (wcnt_q < 32'(IMEM_WORDS))) begin
                    imem_cs   = 1'b1;
                    imem_wr_n = 1'b0;
                    imem_addr = ADDR_W'(wcnt_q) << 2;
                    imem_din  = ld_data;
                    wcnt_d    = wcnt_q + 32'd1;
                end
                if (ld_eof || (wcnt_d >= 32'(IMEM_WORDS))) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == 32'(RST_CYC - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                dut_rst_n = 1'b1;
                dm_cs     = dut_dm_rd | dut_dm_wr;
                dm_rd     = dut_dm_rd;
                dm_wr_n   = ~dut_dm_wr;
                dm_addr   = dut_dm_addr;
                dm_din    = dut_dm_din;
                if (dut_halt || (cnt_q == 32'(RUN_CYC - 1))) begin
                    state_d = S_DUMP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DUMP: begin
                // Read slot k is issued in cycle k; its data reaches the sink in cycle k+1.
                if (cnt_q < 32'(DUMP_WORDS)) begin
                    dm_cs   = 1'b1;
                    dm_rd   = 1'b1;
                    dm_addr = DUMP_BASE + (ADDR_W'(cnt_q) << 2);
                end
                if (cnt_q != 32'd0) begin
                    sink_en   = 1'b1;
                    sink_data = dm_dout;
                end
                if (cnt_q == 32'(DUMP_WORDS)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                end_sim = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_sim_run_sequencer.sv
// Self-checking bench for sim_run_sequencer: random program loads, DUT memory traffic and
// dump contents are checked against a word-level model of the run.
module tb_sim_run_sequencer;

    localparam int IMEM_WORDS = 8;
    localparam int RST_CYC    = 4;
    localparam int RUN_CYC    = 10;
    localparam int DUMP_WORDS = 64;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic        ld_en;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_eof = 1'b0;
    logic        imem_cs, imem_wr_n;
    logic [31:0] imem_addr, imem_din;
    logic        dut_rst_n;
    logic        dut_halt = 1'b0;
    logic        dut_dm_rd = 1'b0;
    logic        dut_dm_wr = 1'b0;
    logic [31:0] dut_dm_addr = '0;
    logic [31:0] dut_dm_din = '0;
    logic        dm_cs, dm_rd, dm_wr_n;
    logic [31:0] dm_addr, dm_din;
    logic [31:0] dm_dout = '0;
    logic        sink_en;
    logic [31:0] sink_data;
    logic        end_sim;
    logic [2:0]  state;

    int n_chk  = 0;
    int n_pass = 0;
    int imem_wr_cnt = 0;
    int sink_cnt = 0;
    logic        mem_reload = 1'b0;
    logic [31:0] dmem     [DUMP_WORDS];
    logic [31:0] seed_mem [DUMP_WORDS];
    logic [31:0] ref_mem  [DUMP_WORDS];

    sim_run_sequencer #(
        .DATA_W(32), .ADDR_W(32), .IMEM_WORDS(IMEM_WORDS), .RST_CYC(RST_CYC),
        .RUN_CYC(RUN_CYC), .DUMP_BASE(32'h0), .DUMP_WORDS(DUMP_WORDS)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start),
        .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data), .ld_eof(ld_eof),
        .imem_cs(imem_cs), .imem_wr_n(imem_wr_n), .imem_addr(imem_addr), .imem_din(imem_din),
        .dut_rst_n(dut_rst_n), .dut_halt(dut_halt),
        .dut_dm_rd(dut_dm_rd), .dut_dm_wr(dut_dm_wr), .dut_dm_addr(dut_dm_addr), .dut_dm_din(dut_dm_din),
        .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr_n(dm_wr_n), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout), .sink_en(sink_en), .sink_data(sink_data),
        .end_sim(end_sim), .state(state)
    );

    always #5 CLK = ~CLK;

    // Data memory with one-cycle read latency, plus strobe counters.
    always @(posedge CLK) begin
        if (mem_reload) begin
            for (int i = 0; i < DUMP_WORDS; i++) dmem[i] <= seed_mem[i];
        end else if (dm_cs && !dm_wr_n) begin
            dmem[dm_addr[7:2]] <= dm_din;
        end
        if (dm_cs && dm_rd) dm_dout <= dmem[dm_addr[7:2]];
        if (imem_cs && !imem_wr_n) imem_wr_cnt <= imem_wr_cnt + 1;
        if (sink_en) sink_cnt <= sink_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
        $fatal(1);
    end

    task automatic reload_mem();
        for (int i = 0; i < DUMP_WORDS; i++) begin
            seed_mem[i] = $urandom;
            ref_mem[i]  = seed_mem[i];
        end
        mem_reload = 1'b1;
        @(posedge CLK); #1;
        mem_reload = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0; start = 1'b1; ld_valid = 1'b1; ld_eof = 1'b1;
        dut_dm_rd = 1'b1; dut_dm_wr = 1'b1; dut_dm_addr = $urandom; dut_dm_din = $urandom;
        repeat (2) @(posedge CLK);
        #1;
        n_chk++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_chk++; if ({ld_en, imem_cs, imem_wr_n, dut_rst_n, dm_cs, dm_rd, dm_wr_n, sink_en, end_sim} !== 9'b001000100)
            $display("FAIL reset_ctrl: got %b want 001000100",
                     {ld_en, imem_cs, imem_wr_n, dut_rst_n, dm_cs, dm_rd, dm_wr_n, sink_en, end_sim});
        else n_pass++;
        n_chk++; if ({imem_addr, imem_din, dm_addr, dm_din, sink_data} !== 160'd0)
            $display("FAIL reset_data: imem_addr=%h imem_din=%h dm_addr=%h dm_din=%h sink=%h want all 0",
                     imem_addr, imem_din, dm_addr, dm_din, sink_data);
        else n_pass++;
        RST_n = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_eof = 1'b0;
        dut_dm_rd = 1'b0; dut_dm_wr = 1'b0;
        @(posedge CLK); #1;
        n_chk++; if (state !== 3'd0) $display("FAIL idle_hold: got %0d want 0", state); else n_pass++;
    endtask

    task automatic load_phase(input int nwords, input bit eof_with_last);
        int offered, mcnt, cyc, wr0, want_cnt;
        bit v, e, wr, done;
        logic [31:0] d;
        offered = 0; mcnt = 0; cyc = 0; done = 0; wr0 = imem_wr_cnt;
        start = 1'b1;
        #1;
        n_chk++; if (state !== 3'd0) $display("FAIL start_idle: got %0d want 0", state); else n_pass++;
        @(posedge CLK); #1;
        start = 1'b0;
        while (!done && cyc < 200) begin
            if (offered < nwords) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
                e = eof_with_last && v && (offered == nwords - 1);
            end else begin
                v = 1'b0; d = '0; e = 1'b1;
            end
            ld_valid = v; ld_data = d; ld_eof = e;
            #1;
            wr = v && (mcnt < IMEM_WORDS);
            n_chk++; if ({state, ld_en} !== {3'd1, 1'b1})
                $display("FAIL load_state: state=%0d ld_en=%b want 1/1", state, ld_en);
            else n_pass++;
            n_chk++; if ({imem_cs, imem_wr_n} !== (wr ? 2'b10 : 2'b01))
                $display("FAIL load_strobe: cs/wr_n=%b%b want %b", imem_cs, imem_wr_n, wr ? 2'b10 : 2'b01);
            else n_pass++;
            if (wr) begin
                n_chk++; if ({imem_addr, imem_din} !== {32'(mcnt * 4), d})
                    $display("FAIL load_word: addr=%h din=%h want addr=%h din=%h", imem_addr, imem_din, mcnt * 4, d);
                else n_pass++;
            end
            if (v) offered++;
            if (wr) mcnt++;
            done = e || (mcnt == IMEM_WORDS);
            @(posedge CLK); #1;
            cyc++;
        end
        ld_valid = 1'b0; ld_eof = 1'b0;
        n_chk++; if (!done) $display("FAIL load_timeout: still loading after %0d cycles", cyc); else n_pass++;
        want_cnt = (nwords < IMEM_WORDS) ? nwords : IMEM_WORDS;
        n_chk++; if (state !== 3'd2) $display("FAIL load_exit: got state %0d want 2", state); else n_pass++;
        n_chk++; if (imem_wr_cnt - wr0 !== want_cnt)
            $display("FAIL load_count: got %0d writes want %0d", imem_wr_cnt - wr0, want_cnt);
        else n_pass++;
    endtask

    task automatic hold_phase();
        int cnt;
        cnt = 0;
        while (state === 3'd2 && cnt < 50) begin
            ld_valid = 1'b1; ld_data = $urandom;
            dut_dm_wr = 1'b1; dut_dm_addr = $urandom;
            #1;
            n_chk++; if ({dut_rst_n, ld_en, imem_cs, dm_cs} !== 4'b0000)
                $display("FAIL hold_idle: rst_n/ld_en/imem_cs/dm_cs=%b want 0000", {dut_rst_n, ld_en, imem_cs, dm_cs});
            else n_pass++;
            cnt++;
            @(posedge CLK); #1;
        end
        ld_valid = 1'b0; dut_dm_wr = 1'b0;
        n_chk++; if (cnt !== RST_CYC) $display("FAIL hold_len: got %0d cycles want %0d", cnt, RST_CYC); else n_pass++;
        n_chk++; if (state !== 3'd3) $display("FAIL hold_exit: got state %0d want 3", state); else n_pass++;
    endtask

    task automatic run_phase(input int halt_at, input bit write_beef);
        int len;
        len = (halt_at >= 0 && halt_at < RUN_CYC) ? halt_at + 1 : RUN_CYC;
        for (int c = 0; c < len; c++) begin
            bit r, w;
            int idx;
            logic [31:0] d;
            if (c == 0 && write_beef) begin
                r = 1'b0; w = 1'b1; idx = 8; d = 32'hDEADBEEF;
            end else begin
                r = ($urandom_range(0, 2) == 0);
                w = !r && ($urandom_range(0, 1) == 1);
                idx = $urandom_range(0, DUMP_WORDS - 1);
                if (write_beef && idx == 8) idx = 9;
                d = $urandom;
            end
            dut_dm_rd = r; dut_dm_wr = w; dut_dm_addr = 32'(idx * 4); dut_dm_din = d;
            dut_halt = (c == halt_at);
            #1;
            n_chk++; if ({state, dut_rst_n} !== {3'd3, 1'b1})
                $display("FAIL run_state: cycle %0d state=%0d rst_n=%b want 3/1", c, state, dut_rst_n);
            else n_pass++;
            n_chk++; if ({dm_cs, dm_rd, dm_wr_n} !== {r | w, r, !w})
                $display("FAIL run_mux: cycle %0d cs/rd/wr_n=%b want %b", c, {dm_cs, dm_rd, dm_wr_n}, {r | w, r, !w});
            else n_pass++;
            if (w) begin
                n_chk++; if ({dm_addr, dm_din} !== {32'(idx * 4), d})
                    $display("FAIL run_wr: addr=%h din=%h want %h %h", dm_addr, dm_din, idx * 4, d);
                else n_pass++;
                ref_mem[idx] = d;
            end
            @(posedge CLK); #1;
        end
        dut_halt = 1'b0; dut_dm_rd = 1'b0; dut_dm_wr = 1'b0;
        n_chk++; if (state !== 3'd4) $display("FAIL run_exit: got state %0d want 4 after %0d cycles", state, len); else n_pass++;
    endtask

    task automatic dump_phase(input bit dut_req, input int abort_at, input bit beef);
        int s0;
        s0 = sink_cnt;
        for (int k = 0; k <= DUMP_WORDS; k++) begin
            dut_dm_rd = dut_req; dut_dm_wr = dut_req; dut_dm_addr = $urandom; dut_dm_din = $urandom;
            if (k == abort_at) begin
                RST_n = 1'b0;
                @(posedge CLK); #1;
                RST_n = 1'b1; dut_dm_rd = 1'b0; dut_dm_wr = 1'b0;
                n_chk++; if ({state, sink_en, end_sim, dm_cs} !== {3'd0, 3'b000})
                    $display("FAIL dump_abort: state=%0d sink_en=%b end_sim=%b dm_cs=%b want 0/0/0/0",
                             state, sink_en, end_sim, dm_cs);
                else n_pass++;
                return;
            end
            #1;
            n_chk++; if ({state, dut_rst_n, dm_wr_n} !== {3'd4, 1'b0, 1'b1})
                $display("FAIL dump_state: k=%0d state=%0d rst_n=%b wr_n=%b want 4/0/1", k, state, dut_rst_n, dm_wr_n);
            else n_pass++;
            if (k < DUMP_WORDS) begin
                n_chk++; if ({dm_cs, dm_rd, dm_addr} !== {2'b11, 32'(k * 4)})
                    $display("FAIL dump_rd: k=%0d cs/rd=%b%b addr=%h want 11 %h", k, dm_cs, dm_rd, dm_addr, k * 4);
                else n_pass++;
            end
            if (k == 0) begin
                n_chk++; if (sink_en !== 1'b0) $display("FAIL dump_sink0: sink_en=%b want 0", sink_en); else n_pass++;
            end else begin
                n_chk++; if ({sink_en, sink_data} !== {1'b1, ref_mem[k-1]})
                    $display("FAIL dump_sink: slot %0d en=%b data=%h want 1 %h", k - 1, sink_en, sink_data, ref_mem[k-1]);
                else n_pass++;
            end
            if (beef && k == 9) begin
                n_chk++; if (sink_data !== 32'hDEADBEEF)
                    $display("FAIL dump_slot8: got %h want deadbeef", sink_data);
                else n_pass++;
            end
            @(posedge CLK); #1;
        end
        dut_dm_rd = 1'b0; dut_dm_wr = 1'b0;
        n_chk++; if ({state, end_sim} !== {3'd5, 1'b1})
            $display("FAIL dump_exit: state=%0d end_sim=%b want 5/1", state, end_sim);
        else n_pass++;
        n_chk++; if (sink_cnt - s0 !== DUMP_WORDS)
            $display("FAIL dump_count: got %0d sink pulses want %0d", sink_cnt - s0, DUMP_WORDS);
        else n_pass++;
    endtask

    task automatic test_done_sticky();
        start = 1'b1; ld_valid = 1'b1; dut_dm_rd = 1'b1; dut_dm_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if ({state, end_sim} !== {3'd5, 1'b1})
                $display("FAIL done_sticky: state=%0d end_sim=%b want 5/1", state, end_sim);
            else n_pass++;
            n_chk++; if ({ld_en, imem_cs, imem_wr_n, dut_rst_n, dm_cs, dm_rd, dm_wr_n, sink_en} !== 8'b00100010)
                $display("FAIL done_idle: got %b want 00100010",
                         {ld_en, imem_cs, imem_wr_n, dut_rst_n, dm_cs, dm_rd, dm_wr_n, sink_en});
            else n_pass++;
            @(posedge CLK); #1;
        end
        start = 1'b0; ld_valid = 1'b0; dut_dm_rd = 1'b0; dut_dm_wr = 1'b0;
    endtask

    task automatic test_basic_run();
        reload_mem();
        load_phase(5, 1'b0);
        hold_phase();
        run_phase(-1, 1'b1);
        dump_phase(1'b0, -1, 1'b1);
        test_done_sticky();
    endtask

    task automatic test_eof_with_last_and_halt();
        reload_mem();
        load_phase(3, 1'b1);
        hold_phase();
        run_phase(3, 1'b0);
        dump_phase(1'b1, -1, 1'b0);
        test_done_sticky();
    endtask

    task automatic test_imem_cap_and_abort();
        reload_mem();
        load_phase(IMEM_WORDS + 4, 1'b0);
        hold_phase();
        run_phase($urandom_range(0, RUN_CYC - 1), 1'b0);
        dump_phase(1'b1, 10, 1'b0);
    endtask

    task automatic test_rerun();
        reload_mem();
        load_phase($urandom_range(1, IMEM_WORDS + 2), $urandom_range(0, 1) == 1);
        hold_phase();
        run_phase($urandom_range(0, RUN_CYC + 4), 1'b1);
        dump_phase($urandom_range(0, 1) == 1, -1, 1'b1);
        test_done_sticky();
    endtask

    initial begin
        @(posedge CLK); #1;
        test_reset();
        test_basic_run();
        test_reset();
        test_eof_with_last_and_halt();
        test_reset();
        test_imem_cap_and_abort();
        test_rerun();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
